// File: rtl/fp_result_pack_q_if.sv
// rtl/fp_result_pack_q_if.sv - beat-in / result-out handshake bundle for fp_result_pack_q
// The master side drives input beats and consumes results, and the slave side is the packer.
interface fp_result_pack_q_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   op_sel;
  logic                   mul_sign;
  logic [EXP_W:0]         mul_exp;
  logic [MAN_W+2:0]       mul_man;
  logic                   mul_exc;
  logic [EXP_W+MAN_W:0]   add_r;
  logic                   add_exc;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   r_o;
  logic                   exc_o;
  logic [2:0]             flags_o;
  logic [CNT_W-1:0]       exc_cnt;

  modport master (
    output in_valid, op_sel, mul_sign, mul_exp, mul_man, mul_exc, add_r, add_exc, out_ready,
    input  in_ready, out_valid, r_o, exc_o, flags_o, exc_cnt
  );

  modport slave (
    input  in_valid, op_sel, mul_sign, mul_exp, mul_man, mul_exc, add_r, add_exc, out_ready,
    output in_ready, out_valid, r_o, exc_o, flags_o, exc_cnt
  );
endinterface

// File: rtl/fp_result_pack_q.sv
// rtl/fp_result_pack_q.sv - FP ALU result select, RNE round, pack, classify and output FIFO
// Packs one beat per push into a DEPTH-entry queue, and counts excepting beats with saturation.
module fp_result_pack_q #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  fp_result_pack_q_if.slave  bus
);
  localparam int R_W   = EXP_W + MAN_W + 1;
  localparam int ENT_W = R_W + 4;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] EXC_ONE  = CNT_W'(1);
  localparam logic [EXP_W+1:0] EXP_INF  = {2'b00, {EXP_W{1'b1}}};

  // Multiply-path rounding
  logic             m_hidden;
  logic             m_guard;
  logic             m_sticky;
  logic             m_inc;
  logic             m_carry;
  logic [MAN_W-1:0] m_frac_in;
  logic [MAN_W:0]   m_frac_sum;
  logic [MAN_W-1:0] m_frac;
  logic [EXP_W+1:0] m_exp;

  always_comb begin
    m_hidden   = bus.mul_man[MAN_W+2];
    m_frac_in  = bus.mul_man[MAN_W+1:2];
    m_guard    = bus.mul_man[1];
    m_sticky   = bus.mul_man[0];
    m_inc      = m_guard & (m_sticky | m_frac_in[0]);
    m_frac_sum = {1'b0, m_frac_in} + {{MAN_W{1'b0}}, m_inc};
    // A fraction wrap only carries out of the significand when the hidden bit is set;
    // otherwise it just promotes a subnormal into the hidden position and frac reads 0.
    m_carry    = m_hidden & m_frac_sum[MAN_W];
    m_frac     = m_carry ? '0 : m_frac_sum[MAN_W-1:0];
    m_exp      = {1'b0, bus.mul_exp} + {{(EXP_W + 1){1'b0}}, m_carry};
  end

  // Result select and classification
  logic [R_W-1:0] new_r;
  logic           new_exc;
  logic [2:0]     new_flags;

  always_comb begin
    new_r     = '0;
    new_exc   = 1'b0;
    new_flags = 3'b000;
    if (bus.op_sel) begin
      if (bus.mul_exc) begin
        new_flags = 3'b100;
        new_exc   = 1'b1;
      end else if (bus.mul_man == '0) begin
        new_r = {bus.mul_sign, {(R_W - 1){1'b0}}};
      end else if (m_exp >= EXP_INF) begin
        new_r     = {bus.mul_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        new_flags = 3'b010;
        new_exc   = 1'b1;
      end else if (m_exp == '0 && m_frac != '0) begin
        new_r     = {bus.mul_sign, {(R_W - 1){1'b0}}};
        new_flags = 3'b001;
        new_exc   = 1'b1;
      end else begin
        new_r = {bus.mul_sign, m_exp[EXP_W-1:0], m_frac};
      end
    end else begin
      new_r     = bus.add_r;
      new_exc   = bus.add_exc;
      new_flags = {bus.add_exc, 2'b00};
    end
  end

  // Output FIFO
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic [CNT_W-1:0] exc_cnt_q;
  logic             full;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;

  assign full      = (occ == OCC_FULL);
  assign not_empty = (occ != '0);
  assign push      = bus.in_valid & ~full;
  assign pop       = not_empty & bus.out_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      exc_cnt_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      occ <= occ + OCC_ONE;
      else if (pop && !push) occ <= occ - OCC_ONE;
      if (push && new_exc && exc_cnt_q != '1) exc_cnt_q <= exc_cnt_q + EXC_ONE;
    end
  end

  // Entry payload needs no reset; the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {new_flags, new_exc, new_r};
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = not_empty;
  assign bus.r_o       = not_empty ? head[R_W-1:0] : '0;
  assign bus.exc_o     = not_empty ? head[R_W] : 1'b0;
  assign bus.flags_o   = not_empty ? head[R_W+3:R_W+1] : 3'b000;
  assign bus.exc_cnt   = exc_cnt_q;
endmodule

// File: tb/tb_fp_result_pack_q.sv
// tb/tb_fp_result_pack_q.sv - self-checking bench for fp_result_pack_q
// Vector table plus backpressure, mid-stream reset and counter saturation sequences.
module tb_fp_result_pack_q;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_result_pack_q_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus ();

  fp_result_pack_q #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        op;
    logic        sign;
    logic [8:0]  exp;
    logic [25:0] man;
    logic        mexc;
    logic [31:0] add_r;
    logic        aexc;
    logic [31:0] r;
    logic        exc;
    logic [2:0]  fl;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        exc;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb[$];
  vec_t tv[16];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  function automatic vec_t mv(string n, logic op, logic s, logic [8:0] e, logic [25:0] m,
                              logic mx, logic [31:0] a, logic ax,
                              logic [31:0] r, logic x, logic [2:0] f);
    vec_t v;
    v.name = n; v.op = op; v.sign = s; v.exp = e; v.man = m; v.mexc = mx;
    v.add_r = a; v.aexc = ax; v.r = r; v.exc = x; v.fl = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input vec_t v);
    int n = 0;
    bus.op_sel   = v.op;
    bus.mul_sign = v.sign;
    bus.mul_exp  = v.exp;
    bus.mul_man  = v.man;
    bus.mul_exc  = v.mexc;
    bus.add_r    = v.add_r;
    bus.add_exc  = v.aexc;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout %s: in_ready=0 after %0d cycles, expected 1", v.name, n);
      bus.in_valid = 1'b0;
    end else begin
      sb.push_back('{v.name, v.r, v.exc, v.fl});
      if (v.exc && exp_cnt != 255) exp_cnt++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  // Scoreboard: every head the consumer accepts must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got r_o=0x%0h, expected no beat", bus.r_o);
      end else begin
        e = sb.pop_front();
        check({e.name, "_r"}, 64'(bus.r_o), 64'(e.r));
        check({e.name, "_exc"}, 64'(bus.exc_o), 64'(e.exc));
        check({e.name, "_flags"}, 64'(bus.flags_o), 64'(e.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mv("one",        1, 0, 9'h07F, {1'b1, 23'h000000, 1'b0, 1'b0}, 0, 0, 0, 32'h3F800000, 0, 3'b000);
    tv[1]  = mv("tie_odd",    1, 0, 9'h080, {1'b1, 23'h000001, 1'b1, 1'b0}, 0, 0, 0, 32'h40000002, 0, 3'b000);
    tv[2]  = mv("tie_even",   1, 0, 9'h080, {1'b1, 23'h000000, 1'b1, 1'b0}, 0, 0, 0, 32'h40000000, 0, 3'b000);
    tv[3]  = mv("carry_inf",  1, 0, 9'h0FE, {1'b1, 23'h7FFFFF, 1'b1, 1'b0}, 0, 0, 0, 32'h7F800000, 1, 3'b010);
    tv[4]  = mv("underflow",  1, 0, 9'h000, {1'b0, 23'h000010, 1'b0, 1'b0}, 0, 0, 0, 32'h00000000, 1, 3'b001);
    tv[5]  = mv("mul_exc",    1, 0, 9'h07F, {1'b1, 23'h000000, 1'b0, 1'b0}, 1, 0, 0, 32'h00000000, 1, 3'b100);
    tv[6]  = mv("neg_zero",   1, 1, 9'h055, 26'h0,                          0, 0, 0, 32'h80000000, 0, 3'b000);
    tv[7]  = mv("sticky_up",  1, 0, 9'h080, {1'b1, 23'h000000, 1'b1, 1'b1}, 0, 0, 0, 32'h40000001, 0, 3'b000);
    tv[8]  = mv("no_round",   1, 1, 9'h081, {1'b1, 23'h123456, 1'b0, 1'b1}, 0, 0, 0, 32'hC0923456, 0, 3'b000);
    tv[9]  = mv("headroom",   1, 1, 9'h100, {1'b1, 23'h000000, 1'b0, 1'b0}, 0, 0, 0, 32'hFF800000, 1, 3'b010);
    tv[10] = mv("exp_ff",     1, 0, 9'h0FF, {1'b1, 23'h000000, 1'b0, 1'b0}, 0, 0, 0, 32'h7F800000, 1, 3'b010);
    tv[11] = mv("exp0_frac0", 1, 0, 9'h000, {1'b1, 23'h000000, 1'b0, 1'b0}, 0, 0, 0, 32'h00000000, 0, 3'b000);
    tv[12] = mv("add_pi",     0, 1, 9'h0FF, 26'h3FFFFFF, 0, 32'hC0490FDB, 0, 32'hC0490FDB, 0, 3'b000);
    tv[13] = mv("add_exc",    0, 0, 9'h000, 26'h0,       0, 32'h7FC00000, 1, 32'h7FC00000, 1, 3'b100);
    tv[14] = mv("exc_vs_zero",1, 1, 9'h000, 26'h0,       1, 0, 0, 32'h00000000, 1, 3'b100);
    tv[15] = mv("add_ign_mul",0, 0, 9'h100, 26'h0,       1, 32'h3F800000, 0, 32'h3F800000, 0, 3'b000);

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_sel    = 1'b0;
    bus.mul_sign  = 1'b0;
    bus.mul_exp   = '0;
    bus.mul_man   = '0;
    bus.mul_exc   = 1'b0;
    bus.add_r     = '0;
    bus.add_exc   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_r_o",       64'(bus.r_o), 64'(0));
    check("rst_exc_o",     64'(bus.exc_o), 64'(0));
    check("rst_flags_o",   64'(bus.flags_o), 64'(0));
    check("rst_exc_cnt",   64'(bus.exc_cnt), 64'(0));
    check("rst_in_ready",  64'(bus.in_ready), 64'(1));
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      push(tv[i]);
      @(negedge clk);
      check({tv[i].name, "_latency"}, 64'(bus.out_valid), 64'(1));
      check({tv[i].name, "_exc_cnt"}, 64'(bus.exc_cnt), 64'(exp_cnt));
    end
    repeat (2) @(negedge clk);
    check("table_drained", 64'(sb.size()), 64'(0));

    // Backpressure: two beats fill the queue, the third waits until the consumer frees space.
    bus.out_ready = 1'b0;
    push(mv("bp0", 0, 0, 0, 0, 0, 32'h11111111, 0, 32'h11111111, 0, 3'b000));
    push(mv("bp1", 0, 0, 0, 0, 0, 32'h22222222, 0, 32'h22222222, 0, 3'b000));
    @(negedge clk);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'(0));
    check("bp_head_held",     64'(bus.r_o), 64'h11111111);
    fork
      push(mv("bp2", 0, 0, 0, 0, 0, 32'h33333333, 0, 32'h33333333, 0, 3'b000));
      begin
        repeat (3) @(posedge clk);
        check("bp_head_still", 64'(bus.r_o), 64'h11111111);
        #2 bus.out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check("bp_drained", 64'(sb.size()), 64'(0));
    check("bp_empty",   64'(bus.out_valid), 64'(0));

    // Mid-stream reset discards queued entries and clears the counter at once.
    bus.out_ready = 1'b0;
    push(tv[12]);
    @(negedge clk);
    check("add_head_r",     64'(bus.r_o), 64'hC0490FDB);
    check("add_head_flags", 64'(bus.flags_o), 64'(0));
    push(tv[13]);
    @(negedge clk);
    check("pre_rst_exc_cnt", 64'(bus.exc_cnt), 64'(exp_cnt));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_exc_cnt",   64'(bus.exc_cnt), 64'(0));
    check("mid_rst_r_o",       64'(bus.r_o), 64'(0));
    check("mid_rst_in_ready",  64'(bus.in_ready), 64'(1));
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    push(tv[1]);
    @(negedge clk);
    check("post_rst_exc_cnt", 64'(bus.exc_cnt), 64'(0));

    // Counter saturation.
    for (int i = 0; i < 260; i++) push(tv[5]);
    repeat (3) @(negedge clk);
    check("exc_cnt_sat", 64'(bus.exc_cnt), 64'(255));
    check("sat_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
